// File: rtl/scancode_ascii_display.sv
// PS/2 Set-2 make code to ASCII via lower/upper lookup ROMs, shown as two hex digits
// on active-low seven-segment displays. Two-stage pipeline, fixed 2-cycle latency.
module scancode_ascii_display (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] scancode,
   input  logic       key_valid,
   input  logic       capital,
   input  logic       shift,
   output logic [7:0] ascii,
   output logic [6:0] hex_lo,
   output logic [6:0] hex_hi
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned SEG_W  = 7;
   localparam logic [SEG_W-1:0]  SEG_BLANK  = 7'h7F;
   localparam logic [BYTE_W-1:0] BREAK_CODE = 8'hF0;

   // Unshifted glyph table; unlisted codes read as 0x00.
   function automatic logic [BYTE_W-1:0] lower_rom(input logic [BYTE_W-1:0] addr);
      logic [BYTE_W-1:0] d;
      d = 8'h00;
      case (addr)
         8'h1C: d = 8'h61;  8'h32: d = 8'h62;  8'h21: d = 8'h63;  8'h23: d = 8'h64;
         8'h24: d = 8'h65;  8'h2B: d = 8'h66;  8'h34: d = 8'h67;  8'h33: d = 8'h68;
         8'h43: d = 8'h69;  8'h3B: d = 8'h6A;  8'h42: d = 8'h6B;  8'h4B: d = 8'h6C;
         8'h3A: d = 8'h6D;  8'h31: d = 8'h6E;  8'h44: d = 8'h6F;  8'h4D: d = 8'h70;
         8'h15: d = 8'h71;  8'h2D: d = 8'h72;  8'h1B: d = 8'h73;  8'h2C: d = 8'h74;
         8'h3C: d = 8'h75;  8'h2A: d = 8'h76;  8'h1D: d = 8'h77;  8'h22: d = 8'h78;
         8'h35: d = 8'h79;  8'h1A: d = 8'h7A;
         8'h45: d = 8'h30;  8'h16: d = 8'h31;  8'h1E: d = 8'h32;  8'h26: d = 8'h33;
         8'h25: d = 8'h34;  8'h2E: d = 8'h35;  8'h36: d = 8'h36;  8'h3D: d = 8'h37;
         8'h3E: d = 8'h38;  8'h46: d = 8'h39;
         8'h0E: d = 8'h60;  8'h4E: d = 8'h2D;  8'h55: d = 8'h3D;  8'h54: d = 8'h5B;
         8'h5B: d = 8'h5D;  8'h5D: d = 8'h5C;  8'h4C: d = 8'h3B;  8'h52: d = 8'h27;
         8'h41: d = 8'h2C;  8'h49: d = 8'h2E;  8'h4A: d = 8'h2F;
         8'h29: d = 8'h20;  8'h5A: d = 8'h0D;  8'h66: d = 8'h08;  8'h0D: d = 8'h09;
         default: d = 8'h00;
      endcase
      return d;
   endfunction

   // Shifted/uppercase glyph table; control codes match the lower table.
   function automatic logic [BYTE_W-1:0] upper_rom(input logic [BYTE_W-1:0] addr);
      logic [BYTE_W-1:0] d;
      d = 8'h00;
      case (addr)
         8'h1C: d = 8'h41;  8'h32: d = 8'h42;  8'h21: d = 8'h43;  8'h23: d = 8'h44;
         8'h24: d = 8'h45;  8'h2B: d = 8'h46;  8'h34: d = 8'h47;  8'h33: d = 8'h48;
         8'h43: d = 8'h49;  8'h3B: d = 8'h4A;  8'h42: d = 8'h4B;  8'h4B: d = 8'h4C;
         8'h3A: d = 8'h4D;  8'h31: d = 8'h4E;  8'h44: d = 8'h4F;  8'h4D: d = 8'h50;
         8'h15: d = 8'h51;  8'h2D: d = 8'h52;  8'h1B: d = 8'h53;  8'h2C: d = 8'h54;
         8'h3C: d = 8'h55;  8'h2A: d = 8'h56;  8'h1D: d = 8'h57;  8'h22: d = 8'h58;
         8'h35: d = 8'h59;  8'h1A: d = 8'h5A;
         8'h45: d = 8'h29;  8'h16: d = 8'h21;  8'h1E: d = 8'h40;  8'h26: d = 8'h23;
         8'h25: d = 8'h24;  8'h2E: d = 8'h25;  8'h36: d = 8'h5E;  8'h3D: d = 8'h26;
         8'h3E: d = 8'h2A;  8'h46: d = 8'h28;
         8'h0E: d = 8'h7E;  8'h4E: d = 8'h5F;  8'h55: d = 8'h2B;  8'h54: d = 8'h7B;
         8'h5B: d = 8'h7D;  8'h5D: d = 8'h7C;  8'h4C: d = 8'h3A;  8'h52: d = 8'h22;
         8'h41: d = 8'h3C;  8'h49: d = 8'h3E;  8'h4A: d = 8'h3F;
         8'h29: d = 8'h20;  8'h5A: d = 8'h0D;  8'h66: d = 8'h08;  8'h0D: d = 8'h09;
         default: d = 8'h00;
      endcase
      return d;
   endfunction

   // Letters follow capital; everything else follows shift.
   function automatic logic is_letter(input logic [BYTE_W-1:0] code);
      logic l;
      l = 1'b0;
      case (code)
         8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
         8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
         8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: l = 1'b1;
         default: l = 1'b0;
      endcase
      return l;
   endfunction

   function automatic logic [SEG_W-1:0] seg7(input logic [3:0] nib);
      logic [SEG_W-1:0] s;
      s = SEG_BLANK;
      case (nib)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   logic [BYTE_W-1:0] lower_q;
   logic [BYTE_W-1:0] upper_q;
   logic [BYTE_W-1:0] scancode_q;
   logic              key_valid_q;
   logic              capital_q;
   logic              shift_q;

   // Stage 1: ROM reads plus flag copies kept aligned with the ROM data.
   always_ff @(posedge clk) begin
      if (rst) begin
         lower_q     <= '0;
         upper_q     <= '0;
         scancode_q  <= '0;
         key_valid_q <= 1'b0;
         capital_q   <= 1'b0;
         shift_q     <= 1'b0;
      end else begin
         lower_q     <= lower_rom(scancode);
         upper_q     <= upper_rom(scancode);
         scancode_q  <= scancode;
         key_valid_q <= key_valid;
         capital_q   <= capital;
         shift_q     <= shift;
      end
   end

   logic [BYTE_W-1:0] sel_c;
   logic              blank_c;

   always_comb begin
      sel_c   = lower_q;
      blank_c = 1'b0;
      if (is_letter(scancode_q)) begin
         if (capital_q) sel_c = upper_q;
      end else begin
         if (shift_q) sel_c = upper_q;
      end
      if (!key_valid_q || scancode_q == BREAK_CODE || sel_c == 8'h00) blank_c = 1'b1;
   end

   // Stage 2: registered character and segment outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         ascii  <= '0;
         hex_lo <= SEG_BLANK;
         hex_hi <= SEG_BLANK;
      end else if (blank_c) begin
         ascii  <= '0;
         hex_lo <= SEG_BLANK;
         hex_hi <= SEG_BLANK;
      end else begin
         ascii  <= sel_c;
         hex_lo <= seg7(sel_c[3:0]);
         hex_hi <= seg7(sel_c[7:4]);
      end
   end

endmodule

// File: tb/tb_scancode_ascii_display.sv
// Randomized scoreboard bench for scancode_ascii_display against a table-driven keyboard model.
module tb_scancode_ascii_display;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] scancode;
   logic       key_valid;
   logic       capital;
   logic       shift;
   logic [7:0] ascii;
   logic [6:0] hex_lo;
   logic [6:0] hex_hi;

   scancode_ascii_display dut (
      .clk       (clk),
      .rst       (rst),
      .scancode  (scancode),
      .key_valid (key_valid),
      .capital   (capital),
      .shift     (shift),
      .ascii     (ascii),
      .hex_lo    (hex_lo),
      .hex_hi    (hex_hi)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [7:0] ascii;
      logic [6:0] hi;
      logic [6:0] lo;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   logic [7:0] low_tab [256];
   logic [7:0] up_tab  [256];
   bit         letter  [256];
   logic [6:0] seg_tab [16];
   logic [7:0] mapped  [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Build the keyboard model from the character lists.
   initial begin
      logic [7:0] lcodes[26];
      logic [7:0] dcodes[10];
      logic [7:0] pcodes[11];
      logic [7:0] pl[11];
      logic [7:0] pu[11];
      string dl, du;
      lcodes = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                 8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
      dcodes = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
      pcodes = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
      dl = "0123456789";   du = ")!@#$%^&*(";
      pl = '{8'h60,8'h2D,8'h3D,8'h5B,8'h5D,8'h5C,8'h3B,8'h27,8'h2C,8'h2E,8'h2F};
      pu = '{8'h7E,8'h5F,8'h2B,8'h7B,8'h7D,8'h7C,8'h3A,8'h22,8'h3C,8'h3E,8'h3F};
      seg_tab = '{7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,
                  7'h00,7'h10,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E};
      for (int i = 0; i < 256; i++) begin
         low_tab[i] = 8'h00; up_tab[i] = 8'h00; letter[i] = 1'b0;
      end
      for (int i = 0; i < 26; i++) begin
         low_tab[lcodes[i]] = 8'h61 + 8'(i);
         up_tab[lcodes[i]]  = 8'h41 + 8'(i);
         letter[lcodes[i]]  = 1'b1;
         mapped.push_back(lcodes[i]);
      end
      for (int i = 0; i < 10; i++) begin
         low_tab[dcodes[i]] = dl[i]; up_tab[dcodes[i]] = du[i]; mapped.push_back(dcodes[i]);
      end
      for (int i = 0; i < 11; i++) begin
         low_tab[pcodes[i]] = pl[i]; up_tab[pcodes[i]] = pu[i]; mapped.push_back(pcodes[i]);
      end
      low_tab[8'h29] = 8'h20; up_tab[8'h29] = 8'h20; mapped.push_back(8'h29);
      low_tab[8'h5A] = 8'h0D; up_tab[8'h5A] = 8'h0D; mapped.push_back(8'h5A);
      low_tab[8'h66] = 8'h08; up_tab[8'h66] = 8'h08; mapped.push_back(8'h66);
      low_tab[8'h0D] = 8'h09; up_tab[8'h0D] = 8'h09; mapped.push_back(8'h0D);
   end

   function automatic exp_t model(input logic [7:0] sc, input logic kv, input logic cap,
                                  input logic sh, input int due);
      exp_t e;
      logic [7:0] ch;
      e.due = due; e.ascii = 8'h00; e.hi = 7'h7F; e.lo = 7'h7F;
      ch = (letter[sc] ? cap : sh) ? up_tab[sc] : low_tab[sc];
      if (kv && sc != 8'hF0 && ch != 8'h00) begin
         e.ascii = ch; e.hi = seg_tab[ch[7:4]]; e.lo = seg_tab[ch[3:0]];
      end
      return e;
   endfunction

   // Apply one input set and record what must appear two edges later.
   task automatic drive(input logic [7:0] sc, input logic kv, input logic cap,
                        input logic sh, input logic r);
      exp_t e;
      scancode = sc; key_valid = kv; capital = cap; shift = sh; rst = r;
      e = model(sc, kv, cap, sh, cyc + 2);
      if (r) begin
         e.ascii = 8'h00; e.hi = 7'h7F; e.lo = 7'h7F;
         if (exp_q.size() > 0 && exp_q[exp_q.size()-1].due == cyc + 1) begin
            exp_q[exp_q.size()-1].ascii = 8'h00;
            exp_q[exp_q.size()-1].hi    = 7'h7F;
            exp_q[exp_q.size()-1].lo    = 7'h7F;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [7:0] sc, input logic kv, input logic cap,
                       input logic sh, input logic r);
      @(posedge clk); #1;
      drive(sc, kv, cap, sh, r);
   endtask

   // Monitor: output is always presented; compare whenever an entry falls due.
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         n_total += 3;
         if (e.due != cyc)
            $display("FAIL sched cyc=%0d got due=%0d required due=%0d", cyc, e.due, cyc);
         if (ascii === e.ascii) n_pass++;
         else $display("FAIL ascii cyc=%0d got %h required %h", cyc, ascii, e.ascii);
         if (hex_hi === e.hi) n_pass++;
         else $display("FAIL hex_hi cyc=%0d got %h required %h", cyc, hex_hi, e.hi);
         if (hex_lo === e.lo) n_pass++;
         else $display("FAIL hex_lo cyc=%0d got %h required %h", cyc, hex_lo, e.lo);
      end
   end

   initial begin
      logic [7:0] sc;
      int pick;
      #1;
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
      step(8'h16, 1'b1, 1'b0, 1'b1, 1'b0);
      step(8'h16, 1'b1, 1'b1, 1'b0, 1'b0);
      step(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
      step(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h32, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b1);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 600; i++) begin
         pick = int'($urandom_range(0, 99));
         if (pick < 70)      sc = mapped[$urandom_range(0, mapped.size() - 1)];
         else if (pick < 80) sc = 8'hF0;
         else                sc = 8'($urandom);
         step(sc, ($urandom_range(0, 9) < 8), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 99) < 3));
      end
      step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk); #1;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain got %0d pending required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
